// File: rtl/arb_mux_4_to_1.sv
// rtl/arb_mux_4_to_1.sv - registered 4-input stream mux, fixed-select or round-robin arbitration
// Optional burst lock port enabled by defining ARB_MUX_LOCK_EN.
module arb_mux_4_to_1 #(
  parameter int bits = 16
) (
  input  logic            clock,
  input  logic            reset,
  input  logic [bits-1:0] w,
  input  logic [bits-1:0] x,
  input  logic [bits-1:0] y,
  input  logic [bits-1:0] z,
  input  logic            w_valid,
  input  logic            x_valid,
  input  logic            y_valid,
  input  logic            z_valid,
  output logic            w_ready,
  output logic            x_ready,
  output logic            y_ready,
  output logic            z_ready,
  input  logic [1:0]      select,
  input  logic            mode,
`ifdef ARB_MUX_LOCK_EN
  input  logic            lock,
`endif
  output logic [bits-1:0] out,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [1:0]      grant
);

  logic [bits-1:0] out_q, out_d;
  logic            out_valid_q, out_valid_d;
  logic [1:0]      grant_q, grant_d;
  logic [1:0]      last_q, last_d;

  logic [3:0]      valid_vec;
  logic [3:0]      ready_vec;
  logic [bits-1:0] data_sel;
  logic [1:0]      cand;
  logic            has_cand;
  logic            locked;
  logic            load;
  logic            fire;
  logic [1:0]      idx;

  assign valid_vec = {z_valid, y_valid, x_valid, w_valid};
  assign load      = ~out_valid_q | out_ready;

`ifdef ARB_MUX_LOCK_EN
  assign locked = mode & lock;
`else
  assign locked = 1'b0;
`endif

  always_comb begin
    cand     = select;
    has_cand = 1'b0;
    idx      = 2'd0;
    if (locked) begin
      cand     = grant_q;
      has_cand = valid_vec[grant_q];
    end else if (!mode) begin
      cand     = select;
      has_cand = valid_vec[select];
    end else begin
      // Scan starts just after the last winner so each channel gets a turn.
      for (int i = 1; i <= 4; i++) begin
        idx = last_q + 2'(i);
        if (!has_cand && valid_vec[idx]) begin
          cand     = idx;
          has_cand = 1'b1;
        end
      end
    end
  end

  always_comb begin
    case (cand)
      2'd0:    data_sel = w;
      2'd1:    data_sel = x;
      2'd2:    data_sel = y;
      default: data_sel = z;
    endcase
  end

  assign fire      = load & has_cand & ~reset;
  assign ready_vec = fire ? (4'b0001 << cand) : 4'b0000;
  assign w_ready   = ready_vec[0];
  assign x_ready   = ready_vec[1];
  assign y_ready   = ready_vec[2];
  assign z_ready   = ready_vec[3];

  always_comb begin
    out_d       = out_q;
    out_valid_d = out_valid_q;
    grant_d     = grant_q;
    last_d      = last_q;
    if (fire) begin
      out_d       = data_sel;
      out_valid_d = 1'b1;
      grant_d     = cand;
      if (mode && !locked) begin
        last_d = cand;
      end
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      out_q       <= '0;
      out_valid_q <= 1'b0;
      grant_q     <= 2'd0;
      last_q      <= 2'd3;
    end else begin
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
      grant_q     <= grant_d;
      last_q      <= last_d;
    end
  end

  assign out       = out_q;
  assign out_valid = out_valid_q;
  assign grant     = grant_q;

endmodule

// File: tb/tb_arb_mux_4_to_1.sv
// tb/tb_arb_mux_4_to_1.sv - directed-vector bench for arb_mux_4_to_1
module tb_arb_mux_4_to_1;

  logic        clock = 1'b0;
  logic        reset;
  logic [15:0] w, x, y, z;
  logic        w_valid, x_valid, y_valid, z_valid;
  logic        w_ready, x_ready, y_ready, z_ready;
  logic [1:0]  select;
  logic        mode;
  logic        lock;
  logic [15:0] out;
  logic        out_valid;
  logic        out_ready;
  logic [1:0]  grant;

  int vecs = 0;
  int errs = 0;

  always #5 clock = ~clock;

  arb_mux_4_to_1 #(.bits(16)) dut (
    .clock(clock), .reset(reset),
    .w(w), .x(x), .y(y), .z(z),
    .w_valid(w_valid), .x_valid(x_valid), .y_valid(y_valid), .z_valid(z_valid),
    .w_ready(w_ready), .x_ready(x_ready), .y_ready(y_ready), .z_ready(z_ready),
    .select(select), .mode(mode),
`ifdef ARB_MUX_LOCK_EN
    .lock(lock),
`endif
    .out(out), .out_valid(out_valid), .out_ready(out_ready), .grant(grant)
  );

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic set_valids(input logic [3:0] v);
    {z_valid, y_valid, x_valid, w_valid} = v;
  endtask

  task automatic test_reset();
    reset = 1'b1; set_valids(4'b1111); out_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      vecs++;
      if ({z_ready, y_ready, x_ready, w_ready} !== 4'b0000) begin
        errs++; $display("FAIL reset_ready got %b exp 0000", {z_ready, y_ready, x_ready, w_ready});
      end
      vecs++;
      if (out !== 16'h0 || out_valid !== 1'b0 || grant !== 2'd0) begin
        errs++; $display("FAIL reset_regs got out=%h ov=%b g=%0d exp 0/0/0", out, out_valid, grant);
      end
    end
    set_valids(4'b0000); reset = 1'b0;
    tick(); tick();
    vecs++;
    if (out_valid !== 1'b0 || grant !== 2'd0 || out !== 16'h0) begin
      errs++; $display("FAIL idle_after_reset got out=%h ov=%b g=%0d exp 0/0/0", out, out_valid, grant);
    end
  endtask

  task automatic test_fixed();
    mode = 1'b0; select = 2'd2; y = 16'hBEEF; w = 16'h1234; set_valids(4'b0101); out_ready = 1'b1;
    #1;
    vecs++;
    if ({z_ready, y_ready, x_ready, w_ready} !== 4'b0100) begin
      errs++; $display("FAIL fixed_ready got %b exp 0100", {z_ready, y_ready, x_ready, w_ready});
    end
    tick();
    vecs++;
    if (out !== 16'hBEEF || out_valid !== 1'b1 || grant !== 2'd2) begin
      errs++; $display("FAIL fixed_out got out=%h ov=%b g=%0d exp beef/1/2", out, out_valid, grant);
    end
    select = 2'd1;
    #1;
    vecs++;
    if ({z_ready, y_ready, x_ready, w_ready} !== 4'b0000) begin
      errs++; $display("FAIL fixed_unselected got %b exp 0000", {z_ready, y_ready, x_ready, w_ready});
    end
    set_valids(4'b0000);
    tick();
    vecs++;
    if (out_valid !== 1'b0 || out !== 16'hBEEF || grant !== 2'd2) begin
      errs++; $display("FAIL fixed_drain got out=%h ov=%b g=%0d exp beef/0/2", out, out_valid, grant);
    end
  endtask

  task automatic test_round_robin();
    mode = 1'b1; w = 16'd1; x = 16'd2; y = 16'd3; z = 16'd4; set_valids(4'b1111); out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      #1;
      vecs++;
      if ({z_ready, y_ready, x_ready, w_ready} !== (4'b0001 << (i % 4))) begin
        errs++; $display("FAIL rr_ready[%0d] got %b exp %b", i, {z_ready, y_ready, x_ready, w_ready}, 4'b0001 << (i % 4));
      end
      tick();
      vecs++;
      if (out !== 16'(i % 4 + 1) || grant !== 2'(i % 4) || out_valid !== 1'b1) begin
        errs++; $display("FAIL rr_out[%0d] got out=%0d g=%0d ov=%b exp %0d/%0d/1", i, out, grant, out_valid, i % 4 + 1, i % 4);
      end
    end
  endtask

  task automatic test_backpressure();
    mode = 1'b0; select = 2'd1; x = 16'hA5A5; set_valids(4'b0010); out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      vecs++;
      if ({z_ready, y_ready, x_ready, w_ready} !== 4'b0000) begin
        errs++; $display("FAIL bp_ready[%0d] got %b exp 0000", i, {z_ready, y_ready, x_ready, w_ready});
      end
      tick();
      vecs++;
      if (out !== 16'd4 || out_valid !== 1'b1 || grant !== 2'd3) begin
        errs++; $display("FAIL bp_hold[%0d] got out=%h ov=%b g=%0d exp 0004/1/3", i, out, out_valid, grant);
      end
    end
    out_ready = 1'b1;
    #1;
    vecs++;
    if ({z_ready, y_ready, x_ready, w_ready} !== 4'b0010) begin
      errs++; $display("FAIL bp_release_ready got %b exp 0010", {z_ready, y_ready, x_ready, w_ready});
    end
    tick();
    vecs++;
    if (out !== 16'hA5A5 || out_valid !== 1'b1 || grant !== 2'd1) begin
      errs++; $display("FAIL bp_drain_fill got out=%h ov=%b g=%0d exp a5a5/1/1", out, out_valid, grant);
    end
    set_valids(4'b0000);
    tick();
    vecs++;
    if (out_valid !== 1'b0 || out !== 16'hA5A5 || grant !== 2'd1) begin
      errs++; $display("FAIL bp_empty got out=%h ov=%b g=%0d exp a5a5/0/1", out, out_valid, grant);
    end
  endtask

  task automatic test_skip_empty();
    mode = 1'b1; w = 16'h00AA; x = 16'h00BB; z = 16'h00DD; out_ready = 1'b1;
    set_valids(4'b0001);
    #1;
    vecs++;
    if ({z_ready, y_ready, x_ready, w_ready} !== 4'b0001) begin
      errs++; $display("FAIL skip_w_ready got %b exp 0001", {z_ready, y_ready, x_ready, w_ready});
    end
    tick();
    set_valids(4'b1000);
    #1;
    vecs++;
    if ({z_ready, y_ready, x_ready, w_ready} !== 4'b1000) begin
      errs++; $display("FAIL skip_z_ready got %b exp 1000", {z_ready, y_ready, x_ready, w_ready});
    end
    tick();
    vecs++;
    if (grant !== 2'd3 || out !== 16'h00DD) begin
      errs++; $display("FAIL skip_z_grant got g=%0d out=%h exp 3/00dd", grant, out);
    end
    set_valids(4'b0010);
    tick();
    vecs++;
    if (grant !== 2'd1 || out !== 16'h00BB || out_valid !== 1'b1) begin
      errs++; $display("FAIL skip_x_grant got g=%0d out=%h ov=%b exp 1/00bb/1", grant, out, out_valid);
    end
    set_valids(4'b0000);
    #1;
    vecs++;
    if ({z_ready, y_ready, x_ready, w_ready} !== 4'b0000) begin
      errs++; $display("FAIL rr_none_ready got %b exp 0000", {z_ready, y_ready, x_ready, w_ready});
    end
    tick();
  endtask

  task automatic test_mode_switch();
    mode = 1'b0; select = 2'd3; z = 16'h0EEE; set_valids(4'b1000); out_ready = 1'b1;
    tick();
    vecs++;
    if (grant !== 2'd3 || out !== 16'h0EEE) begin
      errs++; $display("FAIL switch_fixed got g=%0d out=%h exp 3/0eee", grant, out);
    end
    mode = 1'b1; w = 16'd1; x = 16'd2; y = 16'd3; z = 16'd4; set_valids(4'b1111);
    tick();
    vecs++;
    if (grant !== 2'd2 || out !== 16'd3) begin
      errs++; $display("FAIL switch_resume got g=%0d out=%0d exp 2/3", grant, out);
    end
    set_valids(4'b0000);
    tick();
  endtask

`ifdef ARB_MUX_LOCK_EN
  task automatic test_lock();
    mode = 1'b1; out_ready = 1'b1; lock = 1'b0; set_valids(4'b0010);
    tick();
    lock = 1'b1; set_valids(4'b1111);
    for (int i = 0; i < 3; i++) begin
      #1;
      vecs++;
      if ({z_ready, y_ready, x_ready, w_ready} !== 4'b0010) begin
        errs++; $display("FAIL lock_ready[%0d] got %b exp 0010", i, {z_ready, y_ready, x_ready, w_ready});
      end
      tick();
      vecs++;
      if (grant !== 2'd1 || out !== 16'd2) begin
        errs++; $display("FAIL lock_grant[%0d] got g=%0d out=%0d exp 1/2", i, grant, out);
      end
    end
    set_valids(4'b1101);
    #1;
    vecs++;
    if ({z_ready, y_ready, x_ready, w_ready} !== 4'b0000) begin
      errs++; $display("FAIL lock_stall got %b exp 0000", {z_ready, y_ready, x_ready, w_ready});
    end
    tick();
    lock = 1'b0; set_valids(4'b1111);
    tick();
    vecs++;
    if (grant !== 2'd2 || out !== 16'd3) begin
      errs++; $display("FAIL lock_release got g=%0d out=%0d exp 2/3", grant, out);
    end
  endtask
`endif

  initial begin
    reset = 1'b1; mode = 1'b0; select = 2'd0; lock = 1'b0; out_ready = 1'b0;
    w = '0; x = '0; y = '0; z = '0;
    set_valids(4'b0000);
    test_reset();
    test_fixed();
    test_round_robin();
    test_backpressure();
    test_skip_empty();
    test_mode_switch();
`ifdef ARB_MUX_LOCK_EN
    test_lock();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
